// File: rtl/regwrite_pkg.sv
// Shared constants for the register write-back queue.
// Also holds the default geometry and the entry layout for the 64-bit register bank.
package regwrite_pkg;

    localparam int DEF_DEPTH  = 4;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 64;

    localparam logic REG_RW_WRITE  = 1'b0;
    localparam logic REG_RW_PASS   = 1'b1;
    localparam int   REG_ZERO_ADDR = 0;

    localparam int ENTRY_W = DEF_ADDR_W + 1 + DEF_DATA_W;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic                  rw;
        logic [DEF_DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/regwrite_queue_if.sv
// Producer-side handshake, drain controls, and bypass lookup bundle for regwrite_queue.
interface regwrite_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic              in_rw;
    logic [DATA_W-1:0] in_data;
    logic              out_stall;
    logic              out_E;
    logic              out_RW;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] byp_addr;
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  in_valid, in_addr, in_rw, in_data, out_stall, byp_addr,
        output in_ready, out_E, out_RW, out_addr, out_data, byp_hit, byp_data, count
    );

    modport master (
        output in_valid, in_addr, in_rw, in_data, out_stall, byp_addr,
        input  in_ready, out_E, out_RW, out_addr, out_data, byp_hit, byp_data, count
    );
endinterface

// File: rtl/regwrite_bypass_match.sv
// Newest-match search over the occupied queue slots, walking oldest to newest so
// the last hit seen (closest to wr_ptr) wins.
module regwrite_bypass_match
    import regwrite_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr,
    input  logic [DEPTH-1:0]             ent_rw,
    input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
    input  logic [PTR_W-1:0]             rd_ptr,
    input  logic [CNT_W-1:0]             count,
    input  logic [ADDR_W-1:0]            byp_addr,
    output logic                         hit,
    output logic [DATA_W-1:0]            data
);

    logic              hit_s;
    logic [DATA_W-1:0] data_s;
    logic [PTR_W-1:0]  idx_s;

    // Priority scan over valid entries; register address zero never matches.
    always_comb begin
        hit_s  = 1'b0;
        data_s = {DATA_W{1'b0}};
        idx_s  = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            idx_s = rd_ptr + PTR_W'(k);
            if ((CNT_W'(k) < count) && (ent_rw[idx_s] == REG_RW_WRITE) &&
                (ent_addr[idx_s] == byp_addr) && (byp_addr != ADDR_W'(REG_ZERO_ADDR))) begin
                hit_s  = 1'b1;
                data_s = ent_data[idx_s];
            end else begin
                hit_s  = hit_s;
                data_s = data_s;
            end
        end
    end

    assign hit  = hit_s;
    assign data = data_s;

endmodule

// File: rtl/regwrite_queue.sv
// Write-back FIFO in front of the register bank: buffers producer transactions and
// drains one per cycle onto registered dataIn/E/RW/address controls.
module regwrite_queue
    import regwrite_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input logic          Clk,
    input logic          Rst_n,
    regwrite_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0][ADDR_W-1:0] mem_addr_r;
    logic [DEPTH-1:0]             mem_rw_r;
    logic [DEPTH-1:0][DATA_W-1:0] mem_data_r;

    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nxt_s;

    logic              out_e_r;
    logic              out_rw_r;
    logic [ADDR_W-1:0] out_addr_r;
    logic [DATA_W-1:0] out_data_r;

    logic in_ready_s;
    logic push_s;
    logic drop_s;
    logic enq_s;
    logic pop_s;

    assign in_ready_s = (count_r < CNT_W'(DEPTH));
    assign push_s     = bus.in_valid && in_ready_s;
    // Writes to register zero complete the handshake but are discarded.
    assign drop_s     = (bus.in_addr == ADDR_W'(REG_ZERO_ADDR)) && (bus.in_rw == REG_RW_WRITE);
    assign enq_s      = push_s && !drop_s;
    assign pop_s      = (count_r != {CNT_W{1'b0}}) && !bus.out_stall;

    // Occupancy next-state from enqueue/dequeue combination.
    always_comb begin
        count_nxt_s = count_r;
        case ({enq_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Entry storage; contents are only observed through valid slots.
    always_ff @(posedge Clk) begin
        if (enq_s) begin
            mem_addr_r[wr_ptr_r] <= bus.in_addr;
            mem_rw_r[wr_ptr_r]   <= bus.in_rw;
            mem_data_r[wr_ptr_r] <= bus.in_data;
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (enq_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            count_r <= count_nxt_s;
        end
    end

    // Registered drain port; payload holds when nothing drains.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_e_r    <= 1'b0;
            out_rw_r   <= 1'b0;
            out_addr_r <= {ADDR_W{1'b0}};
            out_data_r <= {DATA_W{1'b0}};
        end else begin
            out_e_r <= pop_s;
            if (pop_s) begin
                out_rw_r   <= mem_rw_r[rd_ptr_r];
                out_addr_r <= mem_addr_r[rd_ptr_r];
                out_data_r <= mem_data_r[rd_ptr_r];
            end
        end
    end

    regwrite_bypass_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bypass (
        .ent_addr (mem_addr_r),
        .ent_rw   (mem_rw_r),
        .ent_data (mem_data_r),
        .rd_ptr   (rd_ptr_r),
        .count    (count_r),
        .byp_addr (bus.byp_addr),
        .hit      (bus.byp_hit),
        .data     (bus.byp_data)
    );

    assign bus.in_ready = in_ready_s;
    assign bus.out_E    = out_e_r;
    assign bus.out_RW   = out_rw_r;
    assign bus.out_addr = out_addr_r;
    assign bus.out_data = out_data_r;
    assign bus.count    = count_r;

endmodule

// File: tb/tb_regwrite_queue.sv
// Directed bench for regwrite_queue: inputs change and outputs are sampled on the
// falling edge, so each check sees the state left by the preceding rising edge.
module tb_regwrite_queue;

    logic Clk;
    logic Rst_n;
    int   checks;
    int   errors;

    regwrite_queue_if #(.DEPTH(4), .ADDR_W(5), .DATA_W(64)) bus ();

    regwrite_queue #(.DEPTH(4), .ADDR_W(5), .DATA_W(64)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_addr   = 5'd0;
        bus.in_rw     = 1'b0;
        bus.in_data   = 64'd0;
        bus.byp_addr  = 5'd0;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        bus.out_stall = 1'b0;
        idle_inputs();
        repeat (3) @(negedge Clk);
        checks++;
        if (bus.out_E !== 1'b0 || bus.count !== 3'd0) begin
            errors++;
            $display("FAIL reset_hold: out_E=%b count=%0d, need 0/0", bus.out_E, bus.count);
        end
        Rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            checks++;
            if (bus.out_E !== 1'b0 || bus.out_data !== 64'd0 || bus.count !== 3'd0 ||
                bus.in_ready !== 1'b1 || bus.byp_hit !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: E=%b data=%h count=%0d rdy=%b hit=%b, need 0/0/0/1/0",
                         c, bus.out_E, bus.out_data, bus.count, bus.in_ready, bus.byp_hit);
            end
        end
    endtask

    task automatic test_single_write();
        bus.in_valid = 1'b1;
        bus.in_addr  = 5'd3;
        bus.in_rw    = 1'b0;
        bus.in_data  = 64'hDEAD_BEEF_0000_0001;
        @(negedge Clk);
        idle_inputs();
        checks++;
        if (bus.count !== 3'd1 || bus.out_E !== 1'b0) begin
            errors++;
            $display("FAIL single_resident: count=%0d E=%b, need 1/0", bus.count, bus.out_E);
        end
        @(negedge Clk);
        checks++;
        if (bus.out_E !== 1'b1 || bus.out_addr !== 5'd3 || bus.out_RW !== 1'b0 ||
            bus.out_data !== 64'hDEAD_BEEF_0000_0001) begin
            errors++;
            $display("FAIL single_drain: E=%b addr=%0d rw=%b data=%h, need 1/3/0/deadbeef00000001",
                     bus.out_E, bus.out_addr, bus.out_RW, bus.out_data);
        end
        @(negedge Clk);
        checks++;
        if (bus.out_E !== 1'b0 || bus.count !== 3'd0 || bus.out_data !== 64'hDEAD_BEEF_0000_0001) begin
            errors++;
            $display("FAIL single_after: E=%b count=%0d data=%h, need 0/0/held",
                     bus.out_E, bus.count, bus.out_data);
        end
    endtask

    task automatic test_fill_stall();
        logic [3:0] exp_cnt [5];
        exp_cnt[0] = 4'd3; exp_cnt[1] = 4'd3; exp_cnt[2] = 4'd2; exp_cnt[3] = 4'd1; exp_cnt[4] = 4'd0;
        bus.out_stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_addr  = 5'(i);
            bus.in_rw    = 1'b0;
            bus.in_data  = 64'(i) * 64'd256;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL fill_ready[%0d]: in_ready=%b, need 1", i, bus.in_ready);
            end
            @(negedge Clk);
        end
        bus.in_addr = 5'd5;
        bus.in_data = 64'd5 * 64'd256;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (bus.in_ready !== 1'b0 || bus.count !== 3'd4 || bus.out_E !== 1'b0) begin
                errors++;
                $display("FAIL fill_full[%0d]: rdy=%b count=%0d E=%b, need 0/4/0",
                         c, bus.in_ready, bus.count, bus.out_E);
            end
            @(negedge Clk);
        end
        bus.out_stall = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            @(negedge Clk);
            if (j == 2) idle_inputs();
            checks++;
            if (bus.out_E !== 1'b1 || bus.out_addr !== 5'(j) || bus.out_data !== 64'(j) * 64'd256 ||
                {1'b0, bus.count} !== exp_cnt[j-1]) begin
                errors++;
                $display("FAIL fill_drain[%0d]: E=%b addr=%0d data=%h count=%0d, need 1/%0d/%h/%0d",
                         j, bus.out_E, bus.out_addr, bus.out_data, bus.count, j,
                         64'(j) * 64'd256, exp_cnt[j-1]);
            end
        end
        @(negedge Clk);
        checks++;
        if (bus.out_E !== 1'b0 || bus.out_addr !== 5'd5 || bus.count !== 3'd0) begin
            errors++;
            $display("FAIL fill_end: E=%b addr=%0d count=%0d, need 0/5/0", bus.out_E, bus.out_addr, bus.count);
        end
    endtask

    task automatic test_bypass();
        logic [63:0] dv [3];
        logic        rv [3];
        dv[0] = 64'h11; dv[1] = 64'h22; dv[2] = 64'h33;
        rv[0] = 1'b0;   rv[1] = 1'b0;   rv[2] = 1'b1;
        bus.out_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_addr  = 5'd7;
            bus.in_rw    = rv[i];
            bus.in_data  = dv[i];
            @(negedge Clk);
        end
        idle_inputs();
        bus.byp_addr = 5'd7;
        #1;
        checks++;
        if (bus.byp_hit !== 1'b1 || bus.byp_data !== 64'h22) begin
            errors++;
            $display("FAIL byp_newest: hit=%b data=%h, need 1/22", bus.byp_hit, bus.byp_data);
        end
        bus.byp_addr = 5'd8;
        #1;
        checks++;
        if (bus.byp_hit !== 1'b0 || bus.byp_data !== 64'd0) begin
            errors++;
            $display("FAIL byp_miss: hit=%b data=%h, need 0/0", bus.byp_hit, bus.byp_data);
        end
        bus.byp_addr = 5'd0;
        #1;
        checks++;
        if (bus.byp_hit !== 1'b0 || bus.byp_data !== 64'd0) begin
            errors++;
            $display("FAIL byp_zero: hit=%b data=%h, need 0/0", bus.byp_hit, bus.byp_data);
        end
        bus.byp_addr  = 5'd7;
        bus.out_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checks++;
            if (bus.out_E !== 1'b1 || bus.out_data !== dv[i] || bus.out_RW !== rv[i]) begin
                errors++;
                $display("FAIL byp_drain[%0d]: E=%b data=%h rw=%b, need 1/%h/%b",
                         i, bus.out_E, bus.out_data, bus.out_RW, dv[i], rv[i]);
            end
            checks++;
            if (bus.byp_hit !== (i == 0) || bus.byp_data !== ((i == 0) ? 64'h22 : 64'd0)) begin
                errors++;
                $display("FAIL byp_during_drain[%0d]: hit=%b data=%h", i, bus.byp_hit, bus.byp_data);
            end
        end
        @(negedge Clk);
        bus.byp_addr = 5'd0;
    endtask

    task automatic test_addr0();
        bus.in_valid = 1'b1;
        bus.in_addr  = 5'd0;
        bus.in_rw    = 1'b0;
        bus.in_data  = 64'hFF;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL a0_ready: in_ready=%b, need 1", bus.in_ready);
        end
        @(negedge Clk);
        idle_inputs();
        checks++;
        if (bus.count !== 3'd0) begin
            errors++;
            $display("FAIL a0_count: count=%0d, need 0", bus.count);
        end
        @(negedge Clk);
        checks++;
        if (bus.out_E !== 1'b0) begin
            errors++;
            $display("FAIL a0_no_pulse: out_E=%b, need 0", bus.out_E);
        end
        bus.in_valid = 1'b1;
        bus.in_addr  = 5'd0;
        bus.in_rw    = 1'b1;
        bus.in_data  = 64'hAB;
        @(negedge Clk);
        idle_inputs();
        checks++;
        if (bus.count !== 3'd1 || bus.out_E !== 1'b0) begin
            errors++;
            $display("FAIL a0_pass_enq: count=%0d E=%b, need 1/0", bus.count, bus.out_E);
        end
        @(negedge Clk);
        checks++;
        if (bus.out_E !== 1'b1 || bus.out_RW !== 1'b1 || bus.out_addr !== 5'd0 || bus.out_data !== 64'hAB) begin
            errors++;
            $display("FAIL a0_pass_drain: E=%b rw=%b addr=%0d data=%h, need 1/1/0/ab",
                     bus.out_E, bus.out_RW, bus.out_addr, bus.out_data);
        end
        @(negedge Clk);
    endtask

    task automatic test_reset_mid_drain();
        bus.out_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_addr  = 5'(10 + i);
            bus.in_rw    = 1'b0;
            bus.in_data  = 64'(i + 1) * 64'h1_0000;
            @(negedge Clk);
        end
        idle_inputs();
        bus.out_stall = 1'b0;
        @(negedge Clk);
        checks++;
        if (bus.out_E !== 1'b1 || bus.out_addr !== 5'd10 || bus.count !== 3'd2) begin
            errors++;
            $display("FAIL rst_pre: E=%b addr=%0d count=%0d, need 1/10/2", bus.out_E, bus.out_addr, bus.count);
        end
        #2;
        Rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_E !== 1'b0 || bus.count !== 3'd0 || bus.out_data !== 64'd0 || bus.out_addr !== 5'd0) begin
            errors++;
            $display("FAIL rst_async: E=%b count=%0d addr=%0d data=%h, need 0/0/0/0",
                     bus.out_E, bus.count, bus.out_addr, bus.out_data);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            checks++;
            if (bus.out_E !== 1'b0 || bus.count !== 3'd0) begin
                errors++;
                $display("FAIL rst_after[%0d]: E=%b count=%0d, need 0/0", c, bus.out_E, bus.count);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_write();
        test_fill_stall();
        test_bypass();
        test_addr0();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/regwrite_queue.md
Name: regwrite_queue

Overview:
- Write-back queue sitting directly upstream of the 64-bit register bank in the SS_CPU datapath.
- Accepts register transactions from execute/memory producers over a valid/ready handshake and buffers up to DEPTH of them.
- Drains one transaction per cycle onto the register's dataIn/E/RW controls, plus a register address.
- Provides a combinational bypass lookup so decode can read a pending write's value before it reaches the register.

Parameters:
DEPTH, 4, number of queue entries (power of two, >=2)
ADDR_W, 5, register address width
DATA_W, 64, data width (matches register bank)

Ports:
Clk  input  1  rising-edge clock
Rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a transaction
in_ready  output  1  queue can accept (count < DEPTH)
in_addr  input  ADDR_W  target register
in_rw  input  1  0 = write Q, 1 = pass-through to dataOut (register RW encoding)
in_data  input  DATA_W  payload
out_stall  input  1  downstream hold; no drain this cycle
out_E  output  1  register enable, one-cycle pulse per drained entry
out_RW  output  1  RW of drained entry
out_addr  output  ADDR_W  address of drained entry
out_data  output  DATA_W  dataIn for register
byp_addr  input  ADDR_W  bypass lookup address
byp_hit  output  1  a queued write (rw=0) to byp_addr exists
byp_data  output  DATA_W  data of newest matching queued write, 0 when no hit
count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (Rst_n low, asynchronous):
  - count, wr_ptr and rd_ptr = 0.
  - out_E = 0, out_RW = 0, out_addr = 0, out_data = 0.
  - Queue contents are don't-care and never visible.
  - Reset mid-operation discards all pending entries; nothing drains on the first edge after release unless an entry was pushed.
- Push: at posedge, if in_valid && in_ready, the entry {addr, rw, data} is written at wr_ptr, and wr_ptr increments mod DEPTH.
  - in_ready = (count < DEPTH), combinational from count only.
  - No full-with-pop pass-through.
- Address-0 rule: a push with in_addr == 0 and in_rw == 0 is accepted (handshake completes) but not enqueued. count is unchanged.
- Drain, at posedge:
  - If count != 0 and !out_stall: out_E <= 1, out_RW/out_addr/out_data <= head entry, rd_ptr increments.
  - Otherwise: out_E <= 0, and out_RW/out_addr/out_data hold their previous values.
- Latency: an entry pushed at edge N is eligible at edge N+1, so out_E is high in the cycle after N+1. Minimum 1 cycle of queue residence; there is no same-cycle flow-through when empty.
- Simultaneous push and pop: count unchanged; both pointers advance. When full, in_ready = 0 even if a pop occurs that edge.
- count update: +1 on push only, -1 on pop only, unchanged otherwise. It never exceeds DEPTH or underflows.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is tracked by count, not pointer compare.
- Ordering: strict FIFO. Entries are never reordered or merged.
- out_stall held high: entries accumulate to DEPTH, in_ready falls, out_E stays 0, out_* hold.
- Bypass:
  - Purely combinational over the valid queue entries only, excluding the out_* register.
  - Considers only rw = 0 entries with addr == byp_addr.
  - The newest (closest to wr_ptr) match wins.
  - byp_addr == 0 always gives byp_hit = 0 and byp_data = 0.
- out_E is never high for two consecutive cycles unless two entries drain back-to-back. Every pulse corresponds to exactly one accepted non-dropped entry.

Decomposition:
- Shared package regwrite_pkg:
  - Constants: REG_RW_WRITE = 0, REG_RW_PASS = 1, REG_ZERO_ADDR = 0.
  - Entry struct/width constant: ENTRY_W = ADDR_W + 1 + DATA_W.
- One sub-module is natural: regwrite_bypass_match, a combinational newest-match priority search over DEPTH entries given rd_ptr and count.
- Storage and pointer logic stay in the top.

Test Plan:
- Reset/idle: hold Rst_n low 3 cycles, release, no valid → out_E=0, out_data=0, count=0, in_ready=1, byp_hit=0 for 10 cycles.
- Single write: push {addr=3, rw=0, data=64'hDEAD_BEEF_0000_0001} at edge 1 → out_E=1 in the cycle after edge 2 with out_addr=3, out_RW=0 and that data; out_E=0 afterwards; count returns to 0.
- Fill under stall: out_stall=1, push 5 entries addr 1..5 → first 4 accepted, count=4, in_ready=0, 5th held. Drop stall → drains addr 1,2,3,4 on consecutive cycles, then 5th accepted and drained.
- Bypass priority: with stall, push writes addr=7 data=0x11, then addr=7 data=0x22, then rw=1 addr=7 data=0x33; byp_addr=7 → byp_hit=1, byp_data=0x22. byp_addr=8 → byp_hit=0, byp_data=0.
- Address-0 drop: push {addr=0, rw=0, data=0xFF} → handshake completes, count stays 0, no out_E pulse. Then push addr=0 rw=1 → enqueued and drained with out_RW=1.
- Async reset mid-drain: 3 entries queued and draining; assert Rst_n low between edges → out_E=0 and count=0 immediately. After release, no further out_E pulses.
